// File: rtl/mul_32bit_acc.sv
// mul_32bit_acc: accumulates ACC_LEN signed 32-bit products into an
// ACC_WIDTH-bit signed sum and hands the result downstream with a
// valid/ready handshake.
// Optional build macro MUL_ACC_SAT_EN: when defined, an overflowing
// addition saturates; otherwise it wraps modulo 2^ACC_WIDTH.
module mul_32bit_acc #(
    parameter int unsigned ACC_LEN   = 16,
    parameter int unsigned ACC_WIDTH = 40
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_clr,
    input  logic                 i_vld,
    input  logic [31:0]          i_res,
    output logic                 o_rdy,
    output logic                 o_vld,
    input  logic                 i_rdy,
    output logic [ACC_WIDTH-1:0] o_acc,
    output logic [8:0]           o_cnt,
    output logic                 o_ovf
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [8:0]           LEN_CNT = 9'(ACC_LEN);
    localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    state_t                 state_q, state_d;
    logic [ACC_WIDTH-1:0]   acc_q, acc_d;
    logic [8:0]             cnt_q, cnt_d;
    logic                   ovf_q, ovf_d;

    logic [ACC_WIDTH-1:0]   res_ext;
    logic [ACC_WIDTH-1:0]   sum;
    logic                   add_ovf;
    logic [ACC_WIDTH-1:0]   add_val;
    logic [8:0]             cnt_inc;

    // Sign-extend the product and form the running sum with overflow detection
    always_comb begin
        res_ext = ACC_WIDTH'($signed(i_res));
        sum     = acc_q + res_ext;
        add_ovf = (acc_q[ACC_WIDTH-1] == res_ext[ACC_WIDTH-1]) &&
                  (sum[ACC_WIDTH-1] != acc_q[ACC_WIDTH-1]);
        cnt_inc = cnt_q + 9'd1;
`ifdef MUL_ACC_SAT_EN
        if (add_ovf) begin
            add_val = acc_q[ACC_WIDTH-1] ? ACC_MIN : ACC_MAX;
        end else begin
            add_val = sum;
        end
`else
        add_val = sum;
`endif
    end

    // Next-state and datapath update; clear overrides every other input
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        if (i_clr) begin
            state_d = IDLE;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_vld) begin
                        acc_d   = res_ext;
                        cnt_d   = 9'd1;
                        ovf_d   = 1'b0;
                        state_d = (LEN_CNT == 9'd1) ? DONE : ACC;
                    end
                end
                ACC: begin
                    if (i_vld) begin
                        acc_d = add_val;
                        cnt_d = cnt_inc;
                        ovf_d = ovf_q | add_ovf;
                        if (cnt_inc == LEN_CNT) begin
                            state_d = DONE;
                        end
                    end
                end
                DONE: begin
                    if (i_rdy) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State and accumulator registers with asynchronous active-low reset
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    // Handshake outputs decode directly from the state register
    always_comb begin
        o_rdy = (state_q != DONE);
        o_vld = (state_q == DONE);
        o_acc = acc_q;
        o_cnt = cnt_q;
        o_ovf = ovf_q;
    end

endmodule

// File: tb/tb_mul_32bit_acc.sv
// Testbench for mul_32bit_acc: three instances (default, ACC_LEN=4,
// ACC_WIDTH=32/ACC_LEN=2) driven by directed and random stimulus, checked
// against an arithmetic frame model and an expected-result scoreboard.
module tb_mul_32bit_acc;

    localparam int NDUT = 3;
    localparam int LEN [NDUT] = '{16, 4, 2};
    localparam int WID [NDUT] = '{40, 40, 32};

    typedef struct {
        longint acc;
        int     cnt;
        bit     ovf;
    } res_t;

    logic        clk;
    logic        rst_n;
    logic        clr_i [NDUT];
    logic        vld_i [NDUT];
    logic        rdy_i [NDUT];
    logic [31:0] res_i [NDUT];
    logic        rdy_o [NDUT];
    logic        vld_o [NDUT];
    logic [8:0]  cnt_o [NDUT];
    logic        ovf_o [NDUT];
    logic [39:0] acc0;
    logic [39:0] acc1;
    logic [31:0] acc2;
    longint      acc_o [NDUT];

    int checks   = 0;
    int failures = 0;

    // model state
    longint m_acc  [NDUT] = '{0, 0, 0};
    int     m_cnt  [NDUT] = '{0, 0, 0};
    bit     m_ovf  [NDUT] = '{0, 0, 0};
    bit     m_done [NDUT] = '{0, 0, 0};
    res_t   q0[$];
    res_t   q1[$];
    res_t   q2[$];

    mul_32bit_acc u_dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_clr(clr_i[0]), .i_vld(vld_i[0]),
        .i_res(res_i[0]), .o_rdy(rdy_o[0]), .o_vld(vld_o[0]), .i_rdy(rdy_i[0]),
        .o_acc(acc0), .o_cnt(cnt_o[0]), .o_ovf(ovf_o[0])
    );

    mul_32bit_acc #(.ACC_LEN(4), .ACC_WIDTH(40)) u_dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_clr(clr_i[1]), .i_vld(vld_i[1]),
        .i_res(res_i[1]), .o_rdy(rdy_o[1]), .o_vld(vld_o[1]), .i_rdy(rdy_i[1]),
        .o_acc(acc1), .o_cnt(cnt_o[1]), .o_ovf(ovf_o[1])
    );

    mul_32bit_acc #(.ACC_LEN(2), .ACC_WIDTH(32)) u_dut2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_clr(clr_i[2]), .i_vld(vld_i[2]),
        .i_res(res_i[2]), .o_rdy(rdy_o[2]), .o_vld(vld_o[2]), .i_rdy(rdy_i[2]),
        .o_acc(acc2), .o_cnt(cnt_o[2]), .o_ovf(ovf_o[2])
    );

    assign acc_o[0] = longint'($signed(acc0));
    assign acc_o[1] = longint'($signed(acc1));
    assign acc_o[2] = longint'($signed(acc2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic longint wrap_w(longint v, int w);
        longint m;
        m = longint'(1) << w;
        v = v & (m - 1);
        if (v >= (m >>> 1)) v = v - m;
        return v;
    endfunction

    task automatic push_exp(int d, res_t r);
        case (d)
            0: q0.push_back(r);
            1: q1.push_back(r);
            default: q2.push_back(r);
        endcase
    endtask

    task automatic clear_exp(int d);
        case (d)
            0: q0.delete();
            1: q1.delete();
            default: q2.delete();
        endcase
    endtask

    function automatic int exp_size(int d);
        case (d)
            0: return q0.size();
            1: return q1.size();
            default: return q2.size();
        endcase
    endfunction

    task automatic pop_exp(int d, output res_t r);
        case (d)
            0: r = q0.pop_front();
            1: r = q1.pop_front();
            default: r = q2.pop_front();
        endcase
    endtask

    task automatic chk(string name, int d, longint act, longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[dut%0d] actual=%0h required=%0h at %0t", name, d, act, exp, $time);
        end
    endtask

    // Behavioural model: frame arithmetic on the true integer sum
    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            for (int d = 0; d < NDUT; d++) begin
                if (!rst_n || clr_i[d]) begin
                    m_acc[d] = 0; m_cnt[d] = 0; m_ovf[d] = 0; m_done[d] = 0;
                    clear_exp(d);
                end else if (m_done[d]) begin
                    if (rdy_i[d]) m_done[d] = 0;
                end else if (vld_i[d]) begin
                    longint p;
                    p = longint'($signed(res_i[d]));
                    if (m_cnt[d] == 0 || m_cnt[d] == LEN[d]) begin
                        m_acc[d] = wrap_w(p, WID[d]);
                        m_cnt[d] = 1;
                        m_ovf[d] = 0;
                    end else begin
                        longint t, mx, mn;
                        t  = m_acc[d] + p;
                        mx = (longint'(1) << (WID[d] - 1)) - 1;
                        mn = -(longint'(1) << (WID[d] - 1));
                        if (t > mx || t < mn) begin
                            m_ovf[d] = 1;
`ifdef MUL_ACC_SAT_EN
                            m_acc[d] = (t > mx) ? mx : mn;
`else
                            m_acc[d] = wrap_w(t, WID[d]);
`endif
                        end else begin
                            m_acc[d] = t;
                        end
                        m_cnt[d] = m_cnt[d] + 1;
                    end
                    if (m_cnt[d] == LEN[d]) begin
                        res_t r;
                        r.acc = m_acc[d]; r.cnt = m_cnt[d]; r.ovf = m_ovf[d];
                        m_done[d] = 1;
                        push_exp(d, r);
                    end
                end
            end
        end
    end

    // Monitor: per-cycle output checks plus scoreboard pop on each delivered result
    initial begin
        forever begin
            @(negedge clk);
            for (int d = 0; d < NDUT; d++) begin
                chk("o_vld", d, longint'(vld_o[d]), longint'(m_done[d]));
                chk("o_rdy", d, longint'(rdy_o[d]), longint'(!m_done[d]));
                chk("o_acc", d, acc_o[d], m_acc[d]);
                chk("o_cnt", d, longint'(cnt_o[d]), longint'(m_cnt[d]));
                chk("o_ovf", d, longint'(ovf_o[d]), longint'(m_ovf[d]));
                if (rst_n && vld_o[d] && rdy_i[d] && !clr_i[d]) begin
                    if (exp_size(d) == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL sb_unexpected[dut%0d] actual=o_vld required=no_result at %0t", d, $time);
                    end else begin
                        res_t r;
                        pop_exp(d, r);
                        chk("sb_acc", d, acc_o[d], r.acc);
                        chk("sb_cnt", d, longint'(cnt_o[d]), longint'(r.cnt));
                        chk("sb_ovf", d, longint'(ovf_o[d]), longint'(r.ovf));
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        for (int d = 0; d < NDUT; d++) begin
            clr_i[d] = 1'b0; vld_i[d] = 1'b0; rdy_i[d] = 1'b1; res_i[d] = '0;
        end
    endtask

    task automatic send(int d, logic [31:0] v);
        vld_i[d] = 1'b1;
        res_i[d] = v;
        step();
    endtask

    function automatic logic [31:0] rand_prod();
        case ($urandom_range(0, 3))
            0: return 32'($signed($urandom_range(0, 200)) - 100);
            1: return $urandom();
            2: return $urandom_range(0, 1) ? 32'h4000_0000 : 32'hC000_0000;
            default: return $urandom_range(0, 1) ? 32'h7FFF_FFFF : 32'h8000_0000;
        endcase
    endfunction

    initial begin
        rst_n = 1'b0;
        idle_all();
        repeat (3) step();
        rst_n = 1'b1;
        step();

        // Scenario 1: 16 back-to-back products of 3
        for (int i = 0; i < 16; i++) send(0, 32'd3);
        vld_i[0] = 1'b0;
        repeat (3) step();

        // Scenario 2: mixed-sign products, ACC_LEN=4
        send(1, 32'hFFFF_FFFF);
        send(1, 32'h0000_0005);
        send(1, 32'hC000_0000);
        send(1, 32'h4000_0000);
        vld_i[1] = 1'b0;
        repeat (3) step();

        // Scenario 3: positive overflow, ACC_WIDTH=32
        send(2, 32'h4000_0000);
        send(2, 32'h4000_0000);
        vld_i[2] = 1'b0;
        repeat (3) step();

        // Scenario 4: backpressure in DONE with i_vld held high
        rdy_i[1] = 1'b0;
        for (int i = 0; i < 4; i++) send(1, 32'd7 + 32'(i));
        res_i[1] = 32'd99;
        repeat (5) step();
        rdy_i[1] = 1'b1;
        step();
        vld_i[1] = 1'b0;
        repeat (2) step();

        // Scenario 5: clear with the 3rd transfer, then reset mid-frame
        send(0, 32'd10);
        send(0, 32'd20);
        clr_i[0] = 1'b1;
        send(0, 32'd30);
        clr_i[0] = 1'b0;
        vld_i[0] = 1'b0;
        step();
        send(0, 32'd1);
        send(0, 32'd2);
        send(0, 32'd3);
        vld_i[0] = 1'b0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        send(0, 32'd5);
        vld_i[0] = 1'b0;
        step();

        // Random traffic on all instances
        for (int c = 0; c < 3000; c++) begin
            for (int d = 0; d < NDUT; d++) begin
                vld_i[d] = ($urandom_range(0, 9) < 7);
                rdy_i[d] = ($urandom_range(0, 9) < 6);
                clr_i[d] = ($urandom_range(0, 99) < 2);
                res_i[d] = rand_prod();
            end
            if ($urandom_range(0, 999) == 0) rst_n = 1'b0;
            step();
            rst_n = 1'b1;
        end

        // Drain outstanding results
        idle_all();
        repeat (40) step();
        for (int d = 0; d < NDUT; d++) begin
            chk("sb_drain", d, longint'(exp_size(d)), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mul_32bit_acc.md
MUL_32BIT_ACC -- requirements
Module: mul_32bit_acc

Interface
REQ-001 Parameter ACC_LEN, default 16: number of products summed per result; legal range 1..256.
REQ-002 Parameter ACC_WIDTH, default 40: accumulator width in bits; legal range 32..48.
REQ-003 i_clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 i_rst_n  input  1  asynchronous, active-low reset.
REQ-005 i_clr  input  1  synchronous clear of the accumulation in progress.
REQ-006 i_vld  input  1  product valid from the upstream 16-bit multiplier.
REQ-007 i_res  input  32  signed two's-complement product.
REQ-008 o_rdy  output  1  block can accept a product this cycle.
REQ-009 o_vld  output  1  accumulated result valid.
REQ-010 i_rdy  input  1  downstream accepts the result.
REQ-011 o_acc  output  ACC_WIDTH  signed accumulated sum.
REQ-012 o_cnt  output  9  number of products accepted in the current frame.
REQ-013 o_ovf  output  1  sticky signed-overflow flag for the current frame.

Function
REQ-014 The block SHALL implement a three-state FSM: IDLE, ACC and DONE.
REQ-015 A product transfer SHALL occur only in a cycle where i_vld=1 and o_rdy=1; i_vld in any other cycle SHALL be ignored (no state change).
REQ-016 o_rdy SHALL be 1 in IDLE and ACC, and 0 in DONE.
REQ-017 o_vld SHALL be 1 only in DONE.
REQ-018 IDLE + transfer: acc <= sign-extended i_res, cnt <= 1, ovf <= 0; next state is ACC, or DONE if ACC_LEN==1.
REQ-019 ACC + transfer: acc <= acc + sign-extended i_res, cnt <= cnt+1; next state is DONE when cnt+1==ACC_LEN, else ACC.
REQ-020 Latency: o_vld SHALL rise the cycle after the ACC_LEN-th transfer; back-to-back transfers SHALL be accepted every cycle.
REQ-021 DONE: o_acc, o_cnt and o_ovf SHALL be held stable until i_rdy=1; on that edge the FSM returns to IDLE.
REQ-022 In IDLE, o_acc, o_cnt and o_ovf SHALL keep the last frame's values until the next transfer.
REQ-023 Overflow SHALL be detected when both operands have equal sign and the ACC_WIDTH-bit sum's sign differs; o_ovf is then set and stays set for the rest of the frame.
REQ-024 i_clr=1 SHALL override every other input, including a simultaneous transfer or i_rdy: acc, cnt and ovf <= 0, o_vld <= 0, state <= IDLE, and no product is accepted that cycle.
REQ-025 cnt SHALL never exceed ACC_LEN and never wrap.

Reset
REQ-026 While i_rst_n=0, asynchronously: state=IDLE, o_acc=0, o_cnt=0, o_ovf=0, o_vld=0, o_rdy=1.
REQ-027 Reset asserted mid-frame or in DONE SHALL discard the frame with no o_vld pulse.
REQ-028 Reset release SHALL be synchronised by the integrator; the block accepts a transfer on the first clock edge after release.

Configuration
REQ-029 Macro MUL_ACC_SAT_EN: when defined, an overflowing addition SHALL clamp acc to the signed maximum (2^(ACC_WIDTH-1)-1) or minimum (-2^(ACC_WIDTH-1)) according to operand sign.
REQ-030 Without MUL_ACC_SAT_EN, an overflowing addition SHALL wrap modulo 2^ACC_WIDTH.
REQ-031 o_ovf behaviour SHALL be identical with and without MUL_ACC_SAT_EN.

Verification
REQ-032 Scenario 1 (defaults): 16 back-to-back transfers of 0x00000003, i_rdy=1 -> o_vld rises one cycle after the 16th transfer; o_acc=48, o_cnt=16, o_ovf=0; next cycle IDLE with o_rdy=1.
REQ-033 Scenario 2 (ACC_LEN=4): products 0xFFFFFFFF (-1), 0x00000005, 0xC0000000, 0x40000000 -> o_acc=4, o_ovf=0.
REQ-034 Scenario 3 (ACC_WIDTH=32, ACC_LEN=2): two products of 0x40000000 -> o_ovf=1; o_acc=0x7FFFFFFF with MUL_ACC_SAT_EN, 0x80000000 without.
REQ-035 Scenario 4 (backpressure): reach DONE with i_rdy=0 for 5 cycles while i_vld=1 -> o_rdy=0, outputs stable, no transfer; i_rdy=1 -> IDLE next cycle.
REQ-036 Scenario 5: i_clr asserted together with the 3rd transfer, then i_rst_n pulsed low mid-frame -> each time o_acc=0, o_cnt=0, IDLE, no o_vld pulse.
